// File: rtl/logic_unit_sched.sv
// +----------------------------------------------------------------------------+
// | logic_unit_sched: round-robin share of one 4-op logic unit by 4 clients     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module logic_unit_sched #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [7:0]           op_in,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  output logic [3:0]           gnt,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           done_id,
  output logic [WIDTH-1:0]     result
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         id_q, id_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         done_id_q, done_id_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               w_found;
  logic [1:0]         w_win;

  function automatic logic [WIDTH-1:0] lu_eval(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = ~(a & b);
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  // Circular first-set search starting at ptr; 2-bit adds wrap 3 -> 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && req[ptr_q + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    gnt_d     = 4'b0000;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (w_found) begin
          id_d    = w_win;
          op_d    = op_in[{w_win, 1'b0} +: 2];
          a_d     = a_in[32'(w_win) * WIDTH +: WIDTH];
          b_d     = b_in[32'(w_win) * WIDTH +: WIDTH];
          gnt_d   = 4'b0001 << w_win;
          busy_d  = 1'b1;
          ptr_d   = w_win + 2'd1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Only the latched operands feed the unit, so live inputs are ignored here.
        result_d  = lu_eval(op_q, a_q, b_q);
        done_d    = 1'b1;
        done_id_d = id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      id_q      <= 2'd0;
      op_q      <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      gnt_q     <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 2'd0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;

endmodule

`default_nettype wire

// File: doc/logic_unit_sched.md
Name: logic_unit_sched

Overview:
- Round-robin scheduler that shares one 4-bit logic unit (AND, OR, NAND, XOR) among four requesters.
- Each requester presents an opcode and two operands with a level request. The block grants one requester at a time, executes the operation, and returns a registered result tagged with the requester ID.
- Sits between the client blocks and the gate-level logic datapath; it is the only block that drives that datapath.

Parameters:
- WIDTH, 4, operand/result width in bits. The bench uses only 4.
- NREQ is fixed at 4 and is not a parameter. ID width is 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  level request, bit i = requester i.
- op_in  in  8  opcode for requester i in bits [2i+1:2i]: 00 AND, 01 OR, 10 NAND, 11 XOR.
- a_in  in  4*WIDTH  operand A for requester i in bits [WIDTH*i +: WIDTH].
- b_in  in  4*WIDTH  operand B, same packing as a_in.
- gnt  out  4  one-hot grant, one-cycle pulse.
- busy  out  1  high while an operation executes.
- done  out  1  one-cycle pulse, result valid.
- done_id  out  2  requester index for the current result.
- result  out  WIDTH  registered logic-unit output.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low.
- Reset values:
  - Zero: gnt, busy, done, done_id, result.
  - Round-robin pointer ptr = 0; FSM = IDLE.
  - Reset asserted mid-operation aborts it: no done is produced, latched operands are discarded.
- FSM states: IDLE, EXEC.
- IDLE (cycle t):
  - req == 0: stay in IDLE, outputs idle.
  - req != 0: winner w = first set bit of req searched circularly from ptr upward (ptr, ptr+1, ... mod 4).
  - On the clock edge ending cycle t:
    - latch op/a/b of requester w and id = w;
    - gnt <= onehot(w); busy <= 1;
    - ptr <= (w+1) mod 4;
    - FSM -> EXEC.
- EXEC (cycle t+1):
  - gnt and busy are high for exactly this cycle.
  - The logic unit computes from the latched operands only; input changes during EXEC have no effect.
  - On the clock edge ending t+1:
    - result <= f(op,a,b); done <= 1; done_id <= id;
    - gnt <= 0; busy <= 0;
    - FSM -> IDLE.
- Latency and throughput:
  - Request sampled at t; gnt visible at t+1; done/result visible at t+2.
  - Maximum throughput is one operation per 2 cycles.
  - done at t+2 coincides with IDLE, so a new arbitration in t+2 gives the next gnt at t+3.
- Requester handshake:
  - Requester must drop req on the edge after it observes gnt, so req is low by t+2.
  - req still high at t+2 counts as a new request. It is arbitrated after other pending requesters because ptr has advanced.
- Result hold: result and done_id hold their values until the next done. done is low otherwise.
- Opcode semantics, bitwise on WIDTH bits:
  - AND = a&b; OR = a|b; NAND = ~(a&b); XOR = a^b.
  - No carry, no width growth.
- Boundary conditions:
  - ptr wraps 3 -> 0.
  - All four requesting at once: service order ptr, ptr+1, ...
  - Single continuous requester: granted every other cycle.
  - req deasserted in the same cycle it is sampled as 0: no grant.
  - Requests arriving during EXEC are not sampled until IDLE.

Test Plan:
- Reset then idle: hold rst_n=0 then release with req=0 for 10 cycles -> all outputs 0, no gnt.
- Single op: req=0001, op0=00, a0=4'hC, b0=4'hA at t -> gnt=0001 at t+1; done=1, done_id=0, result=4'h8 at t+2. Repeat with op0=01/10/11 -> 4'hE / 4'h7 / 4'h6.
- Round-robin fairness: req=1111 held, each requester drops req after its gnt -> grant order 0,1,2,3. Then req=1001 with ptr=0 -> order 0,3.
- Wrap-around: after serving requester 3 (ptr=0), req=1010 -> requester 1 first, then 3.
- Operand isolation: change a1/b1/op_in during EXEC -> result uses the values latched at t.
- Reset mid-op: assert rst_n=0 during EXEC -> no done pulse, result=0, next request with req=0100 is granted to requester 2 (ptr=0 search).
